// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the 5-stage pipeline sequencing controller.
//   state_t        : controller FSM encoding, also exported on the debug port
//   REG_W_DEFAULT  : default register-specifier width
//   flush_t        : per-stage bubble controls {if_id, id_ex, ex_mem}
// ----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        BR_FLUSH = 2'd3
    } state_t;

    localparam int REG_W_DEFAULT = 5;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } flush_t;

endpackage

// File: rtl/hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use comparator. Flags when the load sitting in EX writes
// a register that the instruction in ID reads. Register 0 never counts as a
// dependency because it is hard-wired to zero.
// Ports:
//   IF_ID_rs, IF_ID_rt : source specifiers of the instruction in ID
//   ID_EX_rt           : destination of the instruction in EX
//   ID_EX_memread      : instruction in EX is a load
//   load_use           : dependency detected
// ----------------------------------------------------------------------------
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic [REG_W-1:0] ID_EX_rt,
    input  logic             ID_EX_memread,
    output logic             load_use
);

    logic [REG_W-1:0] src [2];
    logic [1:0]       hit;

    assign src[0] = IF_ID_rs;
    assign src[1] = IF_ID_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit[gi] = (src[gi] == ID_EX_rt);
        end
    endgenerate

    assign load_use = ID_EX_memread && (ID_EX_rt != '0) && (|hit);

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage MIPS datapath. Drives the PC
// and pipeline-register write enables and the per-stage flush controls for
// load-use stalls, taken-branch squash and multi-cycle data-memory waits.
// Enables/flushes are decoded combinationally from the state register and the
// current inputs; event priority is mem_busy > EX_MEM_PCSrc > load-use.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   IF_ID_rs/rt, ID_EX_rt,
//   ID_EX_memread               : load-use operands
//   EX_MEM_PCSrc                : taken branch resolved in MEM
//   mem_busy                    : data memory not ready
//   pc_write .. MEM_WB_write    : register enables
//   IF_ID/ID_EX/EX_MEM_flush    : bubble controls
//   state                       : FSM state (debug)
//   mem_timeout_err             : sticky memory-timeout flag
//
// Optional build macro HAZARD_CTRL_PERF_CNT_EN adds the 32-bit event counters
// lu_stall_cnt, br_flush_cnt and mem_wait_cnt.
// ----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = REG_W_DEFAULT,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IF_ID_rs,
    input  logic [REG_W-1:0] IF_ID_rt,
    input  logic [REG_W-1:0] ID_EX_rt,
    input  logic             ID_EX_memread,
    input  logic             EX_MEM_PCSrc,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic [1:0]       state,
    output logic             mem_timeout_err
`ifdef HAZARD_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]      lu_stall_cnt,
    output logic [31:0]      br_flush_cnt,
    output logic [31:0]      mem_wait_cnt
`endif
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       pending_reg, pending_next;
    logic       err_reg, err_next;

    logic       load_use;
    logic       freeze;     // memory wait: hold every register
    logic       stall;      // load-use: hold PC and IF/ID, bubble into EX
    flush_t     flush;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .IF_ID_rs      (IF_ID_rs),
        .IF_ID_rt      (IF_ID_rt),
        .ID_EX_rt      (ID_EX_rt),
        .ID_EX_memread (ID_EX_memread),
        .load_use      (load_use)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        pending_next  = pending_reg;
        err_next      = err_reg;
        freeze        = 1'b0;
        stall         = 1'b0;
        flush         = '0;

        if (state_reg == MEM_WAIT) begin
            if (mem_busy) begin
                freeze        = 1'b1;
                wait_cnt_next = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;
            end else begin
                // Exit cycle behaves like RUN; a branch deferred by the wait
                // is replayed through BR_FLUSH.
                wait_cnt_next = 8'd0;
                pending_next  = 1'b0;
                if (EX_MEM_PCSrc) begin
                    flush      = '{if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1};
                    state_next = BR_FLUSH;
                end else if (pending_reg) begin
                    state_next = BR_FLUSH;
                end else if (load_use) begin
                    stall      = 1'b1;
                    state_next = LU_STALL;
                end else begin
                    state_next = RUN;
                end
            end
        end else begin
            if (mem_busy) begin
                freeze        = 1'b1;
                wait_cnt_next = 8'd1;
                state_next    = MEM_WAIT;
                if (state_reg == BR_FLUSH) begin
                    pending_next = 1'b1;
                end
            end else if (EX_MEM_PCSrc) begin
                // Branch beats a simultaneous load-use: the stalled
                // instruction is squashed anyway.
                flush      = '{if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1};
                state_next = BR_FLUSH;
            end else if (state_reg == BR_FLUSH) begin
                flush.if_id = 1'b1;
                state_next  = RUN;
            end else if (load_use && (state_reg != LU_STALL)) begin
                // In LU_STALL the bubble already separates the pair.
                stall      = 1'b1;
                state_next = LU_STALL;
            end else begin
                state_next = RUN;
            end
        end

        if (mem_busy && (wait_cnt_next >= TIMEOUT_LIMIT)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
            pending_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            pending_reg  <= pending_next;
            err_reg      <= err_next;
        end
    end

    // During reset the pipeline runs freely with no bubbles.
    assign pc_write        = rst | ~(freeze | stall);
    assign IF_ID_write     = rst | ~(freeze | stall);
    assign ID_EX_write     = rst | ~freeze;
    assign EX_MEM_write    = rst | ~freeze;
    assign MEM_WB_write    = rst | ~freeze;
    assign IF_ID_flush     = ~rst & flush.if_id;
    assign ID_EX_flush     = ~rst & (flush.id_ex | stall);
    assign EX_MEM_flush    = ~rst & flush.ex_mem;
    assign state           = state_reg;
    assign mem_timeout_err = err_reg;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] lu_stall_cnt_reg, br_flush_cnt_reg, mem_wait_cnt_reg;

    // EX/MEM flush is raised only by an accepted branch squash; a replayed
    // BR_FLUSH after a memory wait is not a new squash event.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_stall_cnt_reg <= 32'd0;
            br_flush_cnt_reg <= 32'd0;
            mem_wait_cnt_reg <= 32'd0;
        end else begin
            if (stall) begin
                lu_stall_cnt_reg <= lu_stall_cnt_reg + 32'd1;
            end
            if (flush.ex_mem) begin
                br_flush_cnt_reg <= br_flush_cnt_reg + 32'd1;
            end
            if (state_reg == MEM_WAIT) begin
                mem_wait_cnt_reg <= mem_wait_cnt_reg + 32'd1;
            end
        end
    end

    assign lu_stall_cnt = lu_stall_cnt_reg;
    assign br_flush_cnt = br_flush_cnt_reg;
    assign mem_wait_cnt = mem_wait_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed, table-driven bench for hazard_ctrl (MEM_TIMEOUT=4). Each table
// entry is one clock cycle: inputs driven after the falling edge, outputs
// compared 1 ns later against hand-computed values. Hand-written sequences
// cover a long memory wait and, when built with HAZARD_CTRL_PERF_CNT_EN,
// the event counters.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
    logic       ID_EX_memread, EX_MEM_PCSrc, mem_busy;
    logic       pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
    logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush;
    logic [1:0] state;
    logic       mem_timeout_err;
`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, br_flush_cnt, mem_wait_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .IF_ID_rs        (IF_ID_rs),
        .IF_ID_rt        (IF_ID_rt),
        .ID_EX_rt        (ID_EX_rt),
        .ID_EX_memread   (ID_EX_memread),
        .EX_MEM_PCSrc    (EX_MEM_PCSrc),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .IF_ID_write     (IF_ID_write),
        .ID_EX_write     (ID_EX_write),
        .EX_MEM_write    (EX_MEM_write),
        .MEM_WB_write    (MEM_WB_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_flush     (ID_EX_flush),
        .EX_MEM_flush    (EX_MEM_flush),
        .state           (state),
        .mem_timeout_err (mem_timeout_err)
`ifdef HAZARD_CTRL_PERF_CNT_EN
        ,
        .lu_stall_cnt    (lu_stall_cnt),
        .br_flush_cnt    (br_flush_cnt),
        .mem_wait_cnt    (mem_wait_cnt)
`endif
    );

    // Write-enable order {pc, IF_ID, ID_EX, EX_MEM, MEM_WB}; flush {IF_ID, ID_EX, EX_MEM}.
    localparam logic [4:0] W1 = 5'b11111;
    localparam logic [4:0] W0 = 5'b00000;
    localparam logic [4:0] WS = 5'b00111;

    typedef struct {
        logic       rst;
        logic       memread;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       pcsrc;
        logic       busy;
        logic [1:0] e_st;
        logic [4:0] e_wr;
        logic [2:0] e_fl;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic r, logic mr, logic [4:0] ert, logic [4:0] s, logic [4:0] t,
                                logic pc, logic b, logic [1:0] st, logic [4:0] wr,
                                logic [2:0] fl, logic er);
        vec_t v;
        v.rst = r; v.memread = mr; v.ex_rt = ert; v.rs = s; v.rt = t;
        v.pcsrc = pc; v.busy = b; v.e_st = st; v.e_wr = wr; v.e_fl = fl; v.e_err = er;
        return v;
    endfunction

    function automatic logic [4:0] act_wr();
        return {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write};
    endfunction

    function automatic logic [2:0] act_fl();
        return {IF_ID_flush, ID_EX_flush, EX_MEM_flush};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic mr, input logic [4:0] ert,
                         input logic [4:0] s, input logic [4:0] t,
                         input logic pc, input logic b);
        rst = r; ID_EX_memread = mr; ID_EX_rt = ert; IF_ID_rs = s; IF_ID_rt = t;
        EX_MEM_PCSrc = pc; mem_busy = b;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        //              rst mr  ert  rs  rt  pc  bsy  st  wr  fl    err
        vecs.push_back(mk(1, 1, 5'd2, 5'd2, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 0 reset masks load-use
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 1 idle
        vecs.push_back(mk(0, 1, 5'd2, 5'd2, 5'd7, 0, 0, 2'd0, WS, 3'b010, 0)); // 2 lw $2 -> rs hit
        vecs.push_back(mk(0, 1, 5'd2, 5'd2, 5'd7, 0, 0, 2'd1, W1, 3'b000, 0)); // 3 LU_STALL, no re-stall
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 4 back to RUN
        vecs.push_back(mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 5 $0 never stalls
        vecs.push_back(mk(0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 2'd0, WS, 3'b010, 0)); // 6 rt hit
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd1, W1, 3'b000, 0)); // 7
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 8
        vecs.push_back(mk(0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 2'd0, W1, 3'b111, 0)); // 9 branch beats load-use
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd3, W1, 3'b100, 0)); // 10 BR_FLUSH
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 11
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd0, W0, 3'b000, 0)); // 12 busy x3
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 0)); // 13
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 0)); // 14
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd2, W1, 3'b000, 0)); // 15 exit cycle
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 16 no timeout
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 2'd0, W1, 3'b111, 0)); // 17 branch
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd3, W0, 3'b000, 0)); // 18 busy in BR_FLUSH
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 0)); // 19
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd2, W1, 3'b000, 0)); // 20 exit, pending
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd3, W1, 3'b100, 0)); // 21 deferred flush
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 22
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd0, W0, 3'b000, 0)); // 23 busy
        vecs.push_back(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 2'd2, WS, 3'b010, 0)); // 24 load-use on exit
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd1, W1, 3'b000, 0)); // 25
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 26
        vecs.push_back(mk(0, 1, 5'd6, 5'd0, 5'd6, 0, 0, 2'd0, WS, 3'b010, 0)); // 27 stall
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 2'd1, W1, 3'b111, 0)); // 28 branch in LU_STALL
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd3, W1, 3'b100, 0)); // 29
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 30
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd0, W0, 3'b000, 0)); // 31 busy x6
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 0)); // 32
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 0)); // 33
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 0)); // 34
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 1)); // 35 timeout seen
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 1)); // 36
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd2, W1, 3'b000, 1)); // 37 release
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 1)); // 38 sticky
        vecs.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 39 reset
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 40 error cleared
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd0, W0, 3'b000, 0)); // 41
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd2, W0, 3'b000, 0)); // 42
        vecs.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd0, W1, 3'b000, 0)); // 43 reset mid-wait
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 44
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 2'd0, W1, 3'b111, 0)); // 45 branch
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd3, W0, 3'b000, 0)); // 46 pending set
        vecs.push_back(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd0, W1, 3'b000, 0)); // 47 reset clears it
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 2'd0, W0, 3'b000, 0)); // 48
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd2, W1, 3'b000, 0)); // 49 exit -> RUN
        vecs.push_back(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'd0, W1, 3'b000, 0)); // 50 no replay

        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].memread, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt,
                  vecs[i].pcsrc, vecs[i].busy);
            #1;
            $display("[TB] step %0d rst=%b busy=%b pcsrc=%b st=%0d wr=%b fl=%b err=%b",
                     i, rst, mem_busy, EX_MEM_PCSrc, state, act_wr(), act_fl(), mem_timeout_err);
            chk("writes", i, 32'(act_wr()), 32'(vecs[i].e_wr));
            chk("flushes", i, 32'(act_fl()), 32'(vecs[i].e_fl));
            // state and the error flag are registered; while rst is high only
            // the enables/flushes are defined by the reset behaviour.
            if (!vecs[i].rst) begin
                chk("state", i, 32'(state), 32'(vecs[i].e_st));
                chk("timeout_err", i, 32'(mem_timeout_err), 32'(vecs[i].e_err));
            end
        end

        // Long wait: freeze holds throughout, error appears after 4 busy cycles.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            #1;
            $display("[TB] long-wait %0d st=%0d wr=%b err=%b", c, state, act_wr(), mem_timeout_err);
            chk("long_wr", c, 32'(act_wr()), 32'(W0));
            chk("long_state", c, 32'(state), (c == 0) ? 32'd0 : 32'd2);
            chk("long_err", c, 32'(mem_timeout_err), (c >= 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        $display("[TB] long-wait release st=%0d wr=%b err=%b", state, act_wr(), mem_timeout_err);
        chk("release_wr", 20, 32'(act_wr()), 32'(W1));
        chk("release_state", 20, 32'(state), 32'd2);
        @(negedge clk);
        #1;
        $display("[TB] after release st=%0d err=%b", state, mem_timeout_err);
        chk("after_state", 21, 32'(state), 32'd0);
        chk("after_err", 21, 32'(mem_timeout_err), 32'd1);

`ifdef HAZARD_CTRL_PERF_CNT_EN
        // Branch, freeze during BR_FLUSH for two busy cycles, replay, then
        // one load-use stall.
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("perf_replay_state", 0, 32'(state), 32'd3);
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] perf lu=%0d br=%0d mw=%0d", lu_stall_cnt, br_flush_cnt, mem_wait_cnt);
        chk("lu_stall_cnt", 0, lu_stall_cnt, 32'd1);
        chk("br_flush_cnt", 0, br_flush_cnt, 32'd1);
        chk("mem_wait_cnt", 0, mem_wait_cnt, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
